// File: rtl/decode_execute_reg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : decode_execute_reg
// Purpose  : Decode->Execute pipeline register. Captures the control word and
//            the decode datapath fields and presents them to execute one cycle
//            later. It detects load-use hazards against the instruction it
//            holds, inserts bubbles, applies branch flushes and execute holds,
//            and counts the load-use bubbles it inserts.
// Ports    : clk, rst (async, active-low)
//            *D inputs    : control bits, ALUControlD, RD1/RD2/Imm/PC/PCPlus4,
//                           RS1/RS2/RD specifiers, ValidD
//            FlushE/HoldE : taken-branch flush / execute back-pressure
//            *E outputs   : registered copies of the D fields, ValidE
//            StallD       : combinational hold request to fetch/decode
//            BubbleCnt    : wrapping count of load-use bubbles
// Revision : 1.0 - initial release
// ============================================================================
module decode_execute_reg #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             RegWriteD,
    input  logic             ALUSrcD,
    input  logic             MemWriteD,
    input  logic             ResultSrcD,
    input  logic             BranchD,
    input  logic [2:0]       ALUControlD,
    input  logic [XLEN-1:0]  RD1_D,
    input  logic [XLEN-1:0]  RD2_D,
    input  logic [XLEN-1:0]  Imm_Ext_D,
    input  logic [XLEN-1:0]  PCD,
    input  logic [XLEN-1:0]  PCPlus4D,
    input  logic [4:0]       RS1_D,
    input  logic [4:0]       RS2_D,
    input  logic [4:0]       RD_D,
    input  logic             ValidD,
    input  logic             FlushE,
    input  logic             HoldE,
    output logic             RegWriteE,
    output logic             ALUSrcE,
    output logic             MemWriteE,
    output logic             ResultSrcE,
    output logic             BranchE,
    output logic [2:0]       ALUControlE,
    output logic [XLEN-1:0]  RD1_E,
    output logic [XLEN-1:0]  RD2_E,
    output logic [XLEN-1:0]  Imm_Ext_E,
    output logic [XLEN-1:0]  PCE,
    output logic [XLEN-1:0]  PCPlus4E,
    output logic [4:0]       RS1_E,
    output logic [4:0]       RS2_E,
    output logic [4:0]       RD_E,
    output logic             ValidE,
    output logic             StallD,
    output logic [CNT_W-1:0] BubbleCnt
);

    logic load_use;
    logic take_bubble;
    logic clear_e;
    logic load_d;

    // A valid load in E whose destination (other than x0) is read by the
    // valid instruction in D cannot forward in time: one bubble is needed.
    assign load_use = ValidE & RegWriteE & ResultSrcE & (RD_E != 5'd0) & ValidD &
                      ((RD_E == RS1_D) | (RD_E == RS2_D));

    // A flush discards whatever is entering E, so D never needs to wait then.
    assign StallD = ~FlushE & (HoldE | load_use);

    assign take_bubble = ~FlushE & ~HoldE & load_use;
    assign clear_e     = FlushE | take_bubble;
    assign load_d      = ~FlushE & ~HoldE & ~load_use;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ValidE      <= 1'b0;
            RegWriteE   <= 1'b0;
            ALUSrcE     <= 1'b0;
            MemWriteE   <= 1'b0;
            ResultSrcE  <= 1'b0;
            BranchE     <= 1'b0;
            ALUControlE <= 3'd0;
            RD1_E       <= '0;
            RD2_E       <= '0;
            Imm_Ext_E   <= '0;
            PCE         <= '0;
            PCPlus4E    <= '0;
            RS1_E       <= 5'd0;
            RS2_E       <= 5'd0;
            RD_E        <= 5'd0;
        end else if (clear_e) begin
            ValidE      <= 1'b0;
            RegWriteE   <= 1'b0;
            ALUSrcE     <= 1'b0;
            MemWriteE   <= 1'b0;
            ResultSrcE  <= 1'b0;
            BranchE     <= 1'b0;
            ALUControlE <= 3'd0;
            RD1_E       <= '0;
            RD2_E       <= '0;
            Imm_Ext_E   <= '0;
            PCE         <= '0;
            PCPlus4E    <= '0;
            RS1_E       <= 5'd0;
            RS2_E       <= 5'd0;
            RD_E        <= 5'd0;
        end else if (load_d) begin
            // An invalid slot still carries its datapath fields, but none of
            // its control bits may cause a side effect downstream.
            ValidE      <= ValidD;
            RegWriteE   <= RegWriteD  & ValidD;
            ALUSrcE     <= ALUSrcD    & ValidD;
            MemWriteE   <= MemWriteD  & ValidD;
            ResultSrcE  <= ResultSrcD & ValidD;
            BranchE     <= BranchD    & ValidD;
            ALUControlE <= ALUControlD;
            RD1_E       <= RD1_D;
            RD2_E       <= RD2_D;
            Imm_Ext_E   <= Imm_Ext_D;
            PCE         <= PCD;
            PCPlus4E    <= PCPlus4D;
            RS1_E       <= RS1_D;
            RS2_E       <= RS2_D;
            RD_E        <= RD_D;
        end
        // HoldE alone: every E register keeps its value.
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            BubbleCnt <= '0;
        end else if (take_bubble) begin
            BubbleCnt <= BubbleCnt + CNT_W'(1);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_decode_execute_reg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_decode_execute_reg
// Purpose  : Directed self-checking bench for decode_execute_reg. A reference
//            model predicts each edge's E state and bubble count; predictions
//            go through a scoreboard queue and are compared after the edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_decode_execute_reg;

    localparam int XLEN = 32;
    localparam int CW   = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst;
    logic            RegWriteD, ALUSrcD, MemWriteD, ResultSrcD, BranchD;
    logic [2:0]      ALUControlD;
    logic [XLEN-1:0] RD1_D, RD2_D, Imm_Ext_D, PCD, PCPlus4D;
    logic [4:0]      RS1_D, RS2_D, RD_D;
    logic            ValidD, FlushE, HoldE;
    logic            RegWriteE, ALUSrcE, MemWriteE, ResultSrcE, BranchE;
    logic [2:0]      ALUControlE;
    logic [XLEN-1:0] RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E;
    logic [4:0]      RS1_E, RS2_E, RD_E;
    logic            ValidE, StallD;
    logic [CW-1:0]   BubbleCnt;

    decode_execute_reg #(.XLEN(XLEN), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .RegWriteD(RegWriteD), .ALUSrcD(ALUSrcD), .MemWriteD(MemWriteD),
        .ResultSrcD(ResultSrcD), .BranchD(BranchD), .ALUControlD(ALUControlD),
        .RD1_D(RD1_D), .RD2_D(RD2_D), .Imm_Ext_D(Imm_Ext_D), .PCD(PCD),
        .PCPlus4D(PCPlus4D), .RS1_D(RS1_D), .RS2_D(RS2_D), .RD_D(RD_D),
        .ValidD(ValidD), .FlushE(FlushE), .HoldE(HoldE),
        .RegWriteE(RegWriteE), .ALUSrcE(ALUSrcE), .MemWriteE(MemWriteE),
        .ResultSrcE(ResultSrcE), .BranchE(BranchE), .ALUControlE(ALUControlE),
        .RD1_E(RD1_E), .RD2_E(RD2_E), .Imm_Ext_E(Imm_Ext_E), .PCE(PCE),
        .PCPlus4E(PCPlus4E), .RS1_E(RS1_E), .RS2_E(RS2_E), .RD_E(RD_E),
        .ValidE(ValidE), .StallD(StallD), .BubbleCnt(BubbleCnt)
    );

    typedef struct packed {
        logic        valid, rw, alusrc, mw, rs, br;
        logic [2:0]  alu;
        logic [31:0] rd1, rd2, imm, pc, pcp4;
        logic [4:0]  rs1, rs2, rd;
    } e_t;

    e_t dut_e;
    assign dut_e = {ValidE, RegWriteE, ALUSrcE, MemWriteE, ResultSrcE, BranchE,
                    ALUControlE, RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E,
                    RS1_E, RS2_E, RD_E};

    e_t            m;        // model of the E register contents
    logic [CW-1:0] mcnt;     // model of the bubble counter
    e_t            exp_e_q[$];
    logic [CW-1:0] exp_c_q[$];
    int            checks   = 0;
    int            failures = 0;

    task automatic check(input string tag, input logic [191:0] obs, input logic [191:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_d(input logic v, input logic rw, input logic rs,
                         input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
        ValidD      = v;
        RegWriteD   = rw;
        ResultSrcD  = rs;
        RD_D        = rd;
        RS1_D       = rs1;
        RS2_D       = rs2;
        ALUSrcD     = 1'($urandom);
        MemWriteD   = 1'($urandom);
        BranchD     = 1'($urandom);
        ALUControlD = 3'($urandom);
        RD1_D       = $urandom;
        RD2_D       = $urandom;
        Imm_Ext_D   = $urandom;
        PCD         = $urandom;
        PCPlus4D    = $urandom;
        FlushE      = 1'b0;
        HoldE       = 1'b0;
    endtask

    // Called one time unit after a rising edge with D inputs already driven.
    task automatic tick(input string tag);
        logic          lu;
        e_t            nx;
        logic [CW-1:0] nc;
        e_t            exp_e;
        logic [CW-1:0] exp_c;
        lu = m.valid & m.rw & m.rs & (m.rd != 5'd0) & ValidD &
             ((m.rd == RS1_D) || (m.rd == RS2_D));
        #1;
        check({tag, ":stall"}, 192'(StallD), 192'(~FlushE & (HoldE | lu)));
        nx = m;
        nc = mcnt;
        if (FlushE) begin
            nx = '0;
        end else if (HoldE) begin
            nx = m;
        end else if (lu) begin
            nx = '0;
            nc = mcnt + 1'b1;
        end else begin
            nx = {ValidD, RegWriteD & ValidD, ALUSrcD & ValidD, MemWriteD & ValidD,
                  ResultSrcD & ValidD, BranchD & ValidD, ALUControlD, RD1_D, RD2_D,
                  Imm_Ext_D, PCD, PCPlus4D, RS1_D, RS2_D, RD_D};
        end
        exp_e_q.push_back(nx);
        exp_c_q.push_back(nc);
        @(posedge clk);
        #1;
        m     = nx;
        mcnt  = nc;
        exp_e = exp_e_q.pop_front();
        exp_c = exp_c_q.pop_front();
        check({tag, ":E"},   192'(dut_e),     192'(exp_e));
        check({tag, ":cnt"}, 192'(BubbleCnt), 192'(exp_c));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        e_t frozen;
        rst = 1'b1;
        m = '0;
        mcnt = '0;
        // Reset: every input nonzero while clocks run.
        #1 rst = 1'b0;
        RegWriteD = 1; ALUSrcD = 1; MemWriteD = 1; ResultSrcD = 1; BranchD = 1;
        ALUControlD = 3'd5; RD1_D = 32'h11; RD2_D = 32'h22; Imm_Ext_D = 32'h33;
        PCD = 32'h44; PCPlus4D = 32'h48; RS1_D = 5'd1; RS2_D = 5'd2; RD_D = 5'd3;
        ValidD = 1; FlushE = 1; HoldE = 1;
        repeat (3) @(posedge clk);
        #1;
        check("rst:E",      192'(dut_e),     192'(0));
        check("rst:cnt",    192'(BubbleCnt), 192'(0));
        check("rst:stallF", 192'(StallD),    192'(0));
        FlushE = 0;
        #1 check("rst:stallH", 192'(StallD), 192'(1));
        HoldE = 0;
        #1 check("rst:stall0", 192'(StallD), 192'(0));

        // Release and first transaction.
        @(posedge clk);
        #1 rst = 1'b1;
        set_d(1, 1, 0, 5'd5, 5'd0, 5'd0);
        PCD = 32'h100;
        tick("rel");
        check("rel:valid", 192'(ValidE), 192'(1));
        check("rel:rd",    192'(RD_E),   192'(5));
        check("rel:pc",    192'(PCE),    192'(32'h100));

        // Load-use: one bubble, then the dependent instruction.
        set_d(1, 1, 1, 5'd7, 5'd1, 5'd2);
        tick("ld");
        set_d(1, 1, 0, 5'd9, 5'd3, 5'd7);
        #1 check("lu:stall1", 192'(StallD), 192'(1));
        tick("lu_bub");
        check("lu:validE", 192'(ValidE),    192'(0));
        check("lu:rwE",    192'(RegWriteE), 192'(0));
        check("lu:cnt1",   192'(BubbleCnt), 192'(1));
        tick("lu_dep");
        check("lu:dep_rd", 192'(RD_E),   192'(9));
        check("lu:dep_v",  192'(ValidE), 192'(1));

        // x0 destination never stalls.
        set_d(1, 1, 1, 5'd0, 5'd4, 5'd4);
        tick("x0_ld");
        set_d(1, 1, 0, 5'd6, 5'd0, 5'd0);
        #1 check("x0:stall", 192'(StallD), 192'(0));
        tick("x0_use");
        check("x0:cnt", 192'(BubbleCnt), 192'(1));

        // Non-load producer never stalls.
        set_d(1, 1, 0, 5'd3, 5'd0, 5'd0);
        tick("nl_alu");
        set_d(1, 1, 0, 5'd8, 5'd3, 5'd3);
        #1 check("nl:stall", 192'(StallD), 192'(0));
        tick("nl_use");
        check("nl:cnt", 192'(BubbleCnt), 192'(1));

        // Flush beats hold and load-use.
        set_d(1, 1, 1, 5'd7, 5'd0, 5'd0);
        tick("fl_ld");
        set_d(1, 1, 0, 5'd8, 5'd7, 5'd0);
        HoldE = 1;
        FlushE = 1;
        #1 check("fl:stall", 192'(StallD), 192'(0));
        tick("fl");
        check("fl:E",   192'(dut_e),     192'(0));
        check("fl:cnt", 192'(BubbleCnt), 192'(1));

        // Hold for three cycles while D changes.
        set_d(1, 1, 0, 5'd12, 5'd0, 5'd0);
        tick("hd_ld");
        frozen = m;
        for (int i = 0; i < 3; i++) begin
            set_d(1, 1, 1, 5'(20 + i), 5'(i), 5'(i + 1));
            HoldE = 1;
            #1 check("hd:stall", 192'(StallD), 192'(1));
            tick("hd");
            check("hd:frozen", 192'(dut_e), 192'(frozen));
        end
        set_d(1, 0, 0, 5'd13, 5'd0, 5'd0);
        tick("hd_rel");
        check("hd:rel_rd", 192'(RD_E), 192'(13));

        // Invalid slot: control bits never leak.
        set_d(0, 1, 1, 5'd14, 5'd0, 5'd0);
        MemWriteD = 1;
        BranchD = 1;
        tick("inv");
        check("inv:mw",    192'(MemWriteE), 192'(0));
        check("inv:valid", 192'(ValidE),    192'(0));
        check("inv:br",    192'(BranchE),   192'(0));

        // Asynchronous reset in the middle of a stall.
        set_d(1, 1, 1, 5'd7, 5'd0, 5'd0);
        tick("ar_ld");
        set_d(1, 1, 0, 5'd8, 5'd7, 5'd7);
        #2 rst = 1'b0;
        #1;
        check("ar:E",     192'(dut_e),     192'(0));
        check("ar:cnt",   192'(BubbleCnt), 192'(0));
        check("ar:stall", 192'(StallD),    192'(0));
        m = '0;
        mcnt = '0;
        @(posedge clk);
        #1 rst = 1'b1;
        tick("ar_rel");
        check("ar:rel_cnt", 192'(BubbleCnt), 192'(0));

        // Counter wrap: 2^CW bubbles return it to zero.
        for (int i = 0; i < (1 << CW); i++) begin
            set_d(1, 1, 1, 5'd7, 5'd0, 5'd0);
            tick("wr_ld");
            set_d(1, 1, 0, 5'd8, 5'd7, 5'd0);
            tick("wr_bub");
            if (i == (1 << CW) - 2) begin
                check("wr:max", 192'(BubbleCnt), 192'((1 << CW) - 1));
            end
        end
        check("wr:zero", 192'(BubbleCnt), 192'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/decode_execute_reg.md
# decode_execute_reg

Decode→Execute pipeline register of the RISC-V pipeline core. It captures the control word produced by the control unit and the decode-stage datapath fields (register operands, immediate, register specifiers, PC) and presents them to the execute stage one cycle later. It also detects load-use hazards against the instruction it holds, inserts bubbles, and applies branch flushes and downstream holds. A bubble counter supports performance measurement.

## Interface
- XLEN, 32, datapath width
- CNT_W, 16, bubble counter width
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- RegWriteD, ALUSrcD, MemWriteD, ResultSrcD, BranchD  in  1 each  control bits from the control unit
- ALUControlD  in  3  ALU operation from the control unit
- RD1_D, RD2_D, Imm_Ext_D, PCD, PCPlus4D  in  XLEN each  decode datapath fields
- RS1_D, RS2_D, RD_D  in  5 each  register specifiers
- ValidD  in  1  decode slot holds a real instruction
- FlushE  in  1  taken branch: discard the instruction entering E
- HoldE  in  1  execute cannot advance this cycle
- RegWriteE, ALUSrcE, MemWriteE, ResultSrcE, BranchE, ALUControlE, RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E, RS1_E, RS2_E, RD_E  out  widths as D  registered copies
- ValidE  out  1  execute slot holds a real instruction
- StallD  out  1  combinational: fetch/decode must hold
- BubbleCnt  out  CNT_W  load-use bubbles inserted

## Operation
- LoadUse (combinational) = ValidE & RegWriteE & ResultSrcE & (RD_E ≠ 0) & ValidD & ((RD_E == RS1_D) | (RD_E == RS2_D)).
- StallD = ~FlushE & (HoldE | LoadUse).
- Per-edge update priority, highest first:
  - FlushE: load a bubble.
  - HoldE: all E registers keep their values.
  - LoadUse: load a bubble. D is held upstream via StallD, and the same instruction re-presents next cycle.
  - Otherwise: load all D inputs. ValidE ← ValidD.
- Bubble: every E output is set to 0, including ValidE, all control bits, ALUControlE, the datapath fields and the specifiers.
- ValidD = 0 with no other condition: D fields load as given, except that every control bit is forced to 0. No register write, memory write or branch may leak from an invalid slot.
- BubbleCnt increments by 1 only on edges where the LoadUse bubble is taken, i.e. not on FlushE and not on HoldE. It wraps modulo 2^CNT_W.
- No combinational path from any D input to any E output.

## Timing
- Reset (rst = 0, asynchronous): all E outputs are 0, ValidE = 0 and BubbleCnt = 0, immediately and regardless of clk. StallD then evaluates to 0 unless HoldE is asserted. Release is synchronous to the next rising edge.
- Latency: 1 cycle, D input → E output.
- Load-use costs exactly one bubble:
  - Cycle n: load in E, dependent instruction in D. StallD = 1.
  - Edge n+1: E becomes a bubble, so LoadUse drops.
  - Edge n+2: the dependent instruction enters E.
- HoldE together with LoadUse: E is held, StallD = 1, and BubbleCnt is unchanged.
- FlushE together with LoadUse or HoldE: the flush wins, StallD = 0, and BubbleCnt is unchanged.
- RD_E = 0 never triggers a stall (x0 is not a real destination).
- Reset asserted mid-stall: all state clears at once. There are no pending bubbles after release.

## Test plan
- Reset: with rst low, drive all inputs to nonzero values and toggle clk → every output is 0, BubbleCnt = 0. Release rst, apply ValidD = 1, RegWriteD = 1, RD_D = 5, PCD = 0x100 → after one edge: ValidE = 1, RD_E = 5, PCE = 0x100.
- Load-use: E holds a load (ResultSrcE = 1, RegWriteE = 1, RD_E = 7), D has RS2_D = 7 → StallD = 1. Next edge: ValidE = 0, RegWriteE = 0, BubbleCnt = 1. The following edge: the dependent instruction appears in E.
- No stall for x0, or for a non-load: RD_E = 0 with RS1_D = 0 → StallD = 0. ResultSrcE = 0 with a matching RD → StallD = 0. BubbleCnt is unchanged in both cases.
- Flush priority: FlushE = 1 in the same cycle as LoadUse = 1 and HoldE = 1 → StallD = 0. Next edge: all E outputs are 0 and BubbleCnt is unchanged.
- Hold: HoldE = 1 for 3 cycles while D inputs change every cycle → E outputs stay frozen at their prior values and StallD = 1 throughout. After HoldE falls, the current D inputs load on the next edge.
- Invalid slot and wrap: ValidD = 0 with MemWriteD = 1 → next edge gives MemWriteE = 0, ValidE = 0. Force 2^CNT_W load-use bubbles → BubbleCnt returns to 0.
